// File: rtl/decode_stage.sv
// decode_stage: registered RV32/RV64 decode stage with a 2-entry elastic buffer
module decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic [11:0]     out_csr_addr,
  output logic [4:0]      out_csr_uimm,
  output logic            out_is_csr,
  output logic            out_is_ecall,
  output logic            out_is_ebreak,
  output logic            out_is_mret,
  output logic            out_is_sret,
  output logic            out_is_wfi,
  output logic            out_is_fence,
  output logic            out_is_fence_i,
  output logic            out_is_w,
  output logic            out_illegal
);
  localparam bit RV64 = XLEN == 64;
  if (XLEN != 32 && XLEN != 64) begin : g_xlen_check
    $error("decode_stage: XLEN must be 32 or 64");
  end
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [XLEN-1:0] imm;
    logic [9:0]      flags;
  } entry_t;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state;
  entry_t main_e, skid_e, dec;
  logic [6:0] op;
  logic [2:0] f3;
  logic [11:0] i12;
  logic [31:0] imm32;
  logic fmt_i, legal_op, sys, priv, ecall, ebreak, mret, sret, wfi, ill, accept, pop;
  assign op = in_instr[6:0];
  assign f3 = in_instr[14:12];
  assign i12 = in_instr[31:20];
  assign fmt_i = op == 7'h03 || op == 7'h13 || op == 7'h1b || op == 7'h67 || op == 7'h73;
  assign imm32 = fmt_i ? {{20{in_instr[31]}}, in_instr[31:20]}
               : op == 7'h23 ? {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]}
               : op == 7'h63 ? {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}
               : (op == 7'h37 || op == 7'h17) ? {in_instr[31:12], 12'b0}
               : op == 7'h6f ? {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}
               : 32'b0;
  assign legal_op = in_instr[1:0] == 2'b11 && (op == 7'h03 || op == 7'h23 || op == 7'h63 || op == 7'h6f ||
                    op == 7'h67 || op == 7'h37 || op == 7'h17 || op == 7'h13 || op == 7'h33 || op == 7'h0f ||
                    op == 7'h73 || (RV64 && (op == 7'h1b || op == 7'h3b)));
  assign sys = op == 7'h73;
  assign priv = sys && f3 == 3'd0;
  assign ecall = priv && i12 == 12'h000;
  assign ebreak = priv && i12 == 12'h001;
  assign sret = priv && i12 == 12'h102;
  assign mret = priv && i12 == 12'h302;
  assign wfi = priv && i12 == 12'h105;
  assign ill = !legal_op || (sys && f3 == 3'd4) || (priv && !(ecall || ebreak || sret || mret || wfi)) ||
               (op == 7'h03 && (f3 == 3'd7 || (!RV64 && (f3 == 3'd3 || f3 == 3'd6)))) ||
               (op == 7'h23 && f3 > (RV64 ? 3'd3 : 3'd2)) ||
               (op == 7'h63 && (f3 == 3'd2 || f3 == 3'd3)) ||
               (op == 7'h0f && f3[2:1] != 2'b00);
  assign dec.pc = in_pc;
  assign dec.instr = in_instr;
  assign dec.imm = XLEN'($signed(imm32));
  assign dec.flags = ill ? 10'h001 : {sys && f3 != 3'd0 && f3 != 3'd4, ecall, ebreak, mret, sret, wfi,
                                      op == 7'h0f && f3 == 3'd0, op == 7'h0f && f3 == 3'd1,
                                      RV64 && (op == 7'h1b || op == 7'h3b), 1'b0};
  assign accept = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  // in_ready and out_valid are kept as flops so neither side sees a combinational path
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      out_valid <= 1'b0;
      in_ready <= 1'b1;
      main_e <= '0;
      skid_e <= '0;
    end else if (flush) begin
      state <= EMPTY;
      out_valid <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          main_e <= dec;
          state <= ONE;
          out_valid <= 1'b1;
        end
        ONE: if (accept && pop) begin
          main_e <= dec;
        end else if (accept) begin
          skid_e <= dec;
          state <= FULL;
          in_ready <= 1'b0;
        end else if (pop) begin
          state <= EMPTY;
          out_valid <= 1'b0;
        end
        FULL: if (pop) begin
          main_e <= skid_e;
          state <= ONE;
          in_ready <= 1'b1;
        end
        default: begin
          state <= EMPTY;
          out_valid <= 1'b0;
          in_ready <= 1'b1;
        end
      endcase
    end
  end
  assign out_pc = main_e.pc;
  assign out_instr = main_e.instr;
  assign out_opcode = main_e.instr[6:0];
  assign out_rd = main_e.instr[11:7];
  assign out_funct3 = main_e.instr[14:12];
  assign out_rs1 = main_e.instr[19:15];
  assign out_rs2 = main_e.instr[24:20];
  assign out_funct7 = main_e.instr[31:25];
  assign out_imm = main_e.imm;
  assign out_csr_addr = main_e.instr[31:20];
  assign out_csr_uimm = main_e.instr[19:15];
  assign {out_is_csr, out_is_ecall, out_is_ebreak, out_is_mret, out_is_sret, out_is_wfi,
          out_is_fence, out_is_fence_i, out_is_w, out_illegal} = main_e.flags;
endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised instruction-decode pipeline stage with a valid/ready handshake on both sides. It extracts fields, builds the single format-selected immediate sign-extended to XLEN, and classifies system, fence and illegal instructions. A 2-entry elastic buffer gives full throughput with a registered `in_ready`. It sits between instruction fetch and register read / hazard logic, and supports RV32 and RV64.

## Interface
- `XLEN`, 32: datapath width, either 32 or 64. Any other value is a compile-time error.
- `clk` input 1: clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high.
- `flush` input 1: discards all buffered instructions (branch/trap redirect).
- `in_valid` input 1: fetch presents an instruction.
- `in_ready` output 1: stage can accept; registered.
- `in_instr` input 32: raw instruction word.
- `in_pc` input XLEN: instruction address.
- `out_valid` output 1: decoded instruction available.
- `out_ready` input 1: downstream consumes.
- `out_pc` output XLEN: PC of the decoded instruction.
- `out_instr` output 32: raw word, passed through for trap value.
- `out_opcode` output 7, `out_rd` output 5, `out_rs1` output 5, `out_rs2` output 5, `out_funct3` output 3, `out_funct7` output 7: instruction fields.
- `out_imm` output XLEN: format-selected immediate, sign-extended.
- `out_csr_addr` output 12: instr[31:20].
- `out_csr_uimm` output 5: instr[19:15].
- `out_is_csr`, `out_is_ecall`, `out_is_ebreak`, `out_is_mret`, `out_is_sret`, `out_is_wfi`, `out_is_fence`, `out_is_fence_i`, `out_is_w`, `out_illegal` outputs 1 each: classification flags.

## Operation
- Decode is combinational on the input word. Results are captured into the main entry or the skid entry, and all outputs drive from the main entry.
- Buffer states:
  - EMPTY: main invalid. `in_ready`=1.
  - ONE: main valid, skid invalid. `in_ready`=1.
  - FULL: both valid. `in_ready`=0.
- Definitions: accept = `in_valid`&`in_ready`; pop = `out_valid`&`out_ready`.
- EMPTY: accept → ONE.
- ONE:
  - accept&pop → ONE, with main replaced by the new instruction.
  - accept&!pop → FULL, with the new instruction into skid.
  - pop&!accept → EMPTY.
- FULL: pop → ONE, with skid moved to main. Accept is impossible in FULL.
- Order is strictly preserved, and no instruction is duplicated or dropped except by `flush`/`reset`.
- `flush` → EMPTY next cycle. It overrides accept and pop in the same cycle, and an instruction offered that cycle is discarded.
- Immediate selection by opcode, sign bit instr[31]:
  - I: LOAD 0000011, OP-IMM 0010011, OP-IMM-32 0011011, JALR 1100111, SYSTEM 1110011.
  - S: STORE 0100011.
  - B: BRANCH 1100011, bit0=0.
  - U: LUI 0110111, AUIPC 0010111. Value is {instr[31:12],12'b0} sign-extended to XLEN.
  - J: JAL 1101111, bit0=0.
  - Otherwise 0.
- Flags apply only to SYSTEM, i.e. opcode 1110011:
  - `out_is_csr`: funct3 ∉ {000,100}.
  - With funct3=000: ecall imm=000, ebreak imm=001, sret imm=102, mret imm=302, wfi imm=105.
- `out_is_fence`: opcode 0001111 with funct3=000. `out_is_fence_i`: opcode 0001111 with funct3=001.
- `out_is_w`: opcode 0011011 or 0111011, only when XLEN=64. It is 0 when XLEN=32.
- `out_illegal` is set when any of the following holds:
  - instr[1:0]≠11.
  - Opcode is not in {LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, OP-IMM, OP 0110011, MISC-MEM, SYSTEM}, plus {OP-IMM-32, OP-32} when XLEN=64.
  - SYSTEM with funct3=100.
  - SYSTEM with funct3=000 and the 12-bit immediate is not one of the five listed values.
  - LOAD with funct3 = 111, or funct3 = 011/110 when XLEN=32.
  - STORE with funct3 > 010 (RV32) or > 011 (RV64).
  - BRANCH with funct3 ∈ {010,011}.
- When `out_illegal`=1, all other classification flags are 0.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is visible on `out_*` after edge N.
- Throughput is 1 instruction per cycle while `out_ready`=1.
- `in_ready` depends only on state and does not depend combinationally on `out_ready`.
- `out_*` are stable while `out_valid`=1 and `out_ready`=0.
- After `reset`: `out_valid`=0, `in_ready`=1, all `out_*` data and flags = 0.
- `reset` asserted mid-transfer drops both entries. Reset has priority over `flush`.

## Test plan
- `in_instr`=0xFFF00093 (addi x1,x0,-1), pc=0x100 → one cycle later `out_valid`=1, `out_rd`=1, `out_imm`=all ones at XLEN, `out_pc`=0x100, `out_illegal`=0.
- Stream 0x00000073, 0x00100073, 0x30200073, 0x10200073, 0x10500073 back-to-back with `out_ready`=1 → ecall, ebreak, mret, sret, wfi flags asserted exactly once each, in order, no bubbles.
- Hold `out_ready`=0 while offering 3 instructions → 2 accepted, `in_ready`=0 on the third. Then release `out_ready` → outputs in order A, B, C, and C is accepted the cycle after the first pop.
- FULL state with `flush`=1 and `in_valid`=1 → next cycle `out_valid`=0, `in_ready`=1, and the offered instruction never appears.
- XLEN=64: 0xFFF0009B (addiw) → `out_is_w`=1, `out_imm`=0xFFFF_FFFF_FFFF_FFFF. XLEN=32: same word → `out_illegal`=1.
- 0x00004073 (SYSTEM funct3=100) and 0x0000000F|0x7000 → `out_illegal`=1. 0x0000100F → `out_is_fence_i`=1.
